// File: rtl/ram32x4_sp.sv
// ram32x4_sp: single-port synchronous RAM, 32 words x 4 bits.
// The address is registered on the way in and the read data on the way out,
// so read latency is two rising edges. A write and the read of the same
// address on the same edge return the new data (write-through).
// Optional macro RAM32X4_SP_CLEAR_ON_RESET_EN: when defined, reset_n low also
// clears every storage word asynchronously; when undefined, storage keeps its
// contents across reset and powers up uninitialised.
module ram32x4_sp #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  wren,
  output logic [DATA_WIDTH-1:0] q
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_q;

  // Address register and output register; reset drops any read in flight.
  // r_q reads the array after the previous edge's write has landed, which is
  // what gives write-through behaviour for a same-address read.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_addr <= '0;
      r_q    <= '0;
    end else begin
      r_addr <= address;
      r_q    <= r_mem[r_addr];
    end
  end

`ifdef RAM32X4_SP_CLEAR_ON_RESET_EN
  // Storage write port; reset clears the whole array and blocks writes.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (wren) begin
      r_mem[address] <= data;
    end
  end
`else
  logic w_we;

  // A write is only honoured while reset is released.
  assign w_we = wren & reset_n;

  // Storage write port; contents survive reset.
  always_ff @(posedge clock) begin
    if (w_we) begin
      r_mem[address] <= data;
    end
  end
`endif

  assign q = r_q;

endmodule

// File: tb/tb_ram32x4_sp.sv
// tb_ram32x4_sp: self-checking bench for ram32x4_sp with a behavioural model
// and a per-cycle compare process, plus literal expectations for the directed
// scenarios.
module tb_ram32x4_sp;

  logic       clock;
  logic       reset_n;
  logic [4:0] address;
  logic [3:0] data;
  logic       wren;
  logic [3:0] q;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  ram32x4_sp #(.DATA_WIDTH(4), .ADDR_WIDTH(5)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .address (address),
    .data    (data),
    .wren    (wren),
    .q       (q)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model: the word array, the address sampled at the last edge,
  // and the value q must hold (the word at that address, as the array stood
  // after that edge's write).
  logic [3:0] m_mem [32];
  logic [4:0] m_last_addr;
  logic [3:0] m_q;

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_last_addr <= 5'd0;
      m_q         <= 4'd0;
`ifdef RAM32X4_SP_CLEAR_ON_RESET_EN
      for (int i = 0; i < 32; i++) m_mem[i] <= 4'd0;
`endif
    end else begin
      m_q         <= m_mem[m_last_addr];
      m_last_addr <= address;
      if (wren) m_mem[address] <= data;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (cmp_en && !$isunknown(m_q)) begin
      checks++;
      if (q !== m_q) begin
        failures++;
        $display("FAIL model_q t=%0t addr_last=%0d q=%b expected=%b",
                 $time, m_last_addr, q, m_q);
      end
    end
  end

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t q=%b expected=%b", name, $time, act, exp);
    end
  endtask

  // Wait for the falling edge, then drive the inputs sampled by the next rising edge.
  task automatic step(input logic [4:0] a, input logic [3:0] d, input logic w);
    @(negedge clock);
    address = a;
    data    = d;
    wren    = w;
  endtask

  logic [3:0] exp_mem0;
  logic [3:0] exp_1f;

  initial begin
    address = 5'd0;
    data    = 4'd0;
    wren    = 1'b0;
    reset_n = 1'b0;
`ifdef RAM32X4_SP_CLEAR_ON_RESET_EN
    exp_mem0 = 4'h0;
    exp_1f   = 4'h0;
`else
    exp_mem0 = 4'hF;
    exp_1f   = 4'hC;
`endif
    repeat (3) @(negedge clock);
    check("reset_q", q, 4'h0);
    reset_n = 1'b1;
    cmp_en  = 1'b1;

    // Write/readback
    step(5'h0A, 4'b1010, 1'b1);
    step(5'h02, 4'b0101, 1'b1);
    step(5'h0A, 4'h0, 1'b0);
    step(5'h0A, 4'h0, 1'b0);
    step(5'h02, 4'h0, 1'b0);
    check("wr_rb_0A", q, 4'b1010);
    step(5'h02, 4'h0, 1'b0);
    step(5'h02, 4'h0, 1'b0);
    check("wr_rb_02", q, 4'b0101);

    // Latency: back-to-back reads 0A, 02, 0A
    step(5'h0A, 4'h0, 1'b0);
    step(5'h02, 4'h0, 1'b0);
    step(5'h0A, 4'h0, 1'b0);
    check("lat_0", q, 4'b1010);
    step(5'h0A, 4'h0, 1'b0);
    check("lat_1", q, 4'b0101);
    step(5'h0A, 4'h0, 1'b0);
    check("lat_2", q, 4'b1010);

    // Read-during-write on the same address
    step(5'h1F, 4'h3, 1'b1);
    step(5'h1F, 4'hC, 1'b1);
    step(5'h1F, 4'h0, 1'b0);
    check("rdw_old", q, 4'h3);
    step(5'h1F, 4'h0, 1'b0);
    check("rdw_new", q, 4'hC);
    step(5'h1F, 4'h0, 1'b0);
    check("rdw_hold", q, 4'hC);

    // Full sweep: mem[i] = i[3:0] ^ 4'hF, then read all 32
    for (int i = 0; i < 32; i++) begin
      logic [4:0] a;
      a = 5'(i);
      step(a, a[3:0] ^ 4'hF, 1'b1);
    end
    for (int i = 0; i < 34; i++) begin
      logic [4:0] a;
      logic [4:0] b;
      a = (i < 32) ? 5'(i) : 5'd0;
      step(a, 4'h0, 1'b0);
      if (i >= 2) begin
        b = 5'(i - 2);
        check($sformatf("sweep_%0d", i - 2), q, b[3:0] ^ 4'hF);
      end
    end

    // Async reset while q shows 4'hC
    step(5'h1F, 4'hC, 1'b1);
    step(5'h1F, 4'h0, 1'b0);
    step(5'h1F, 4'h0, 1'b0);
    step(5'h1F, 4'h0, 1'b0);
    check("pre_reset_q", q, 4'hC);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_q", q, 4'h0);
    wren    = 1'b1;
    data    = 4'h7;
    address = 5'h1F;
    @(negedge clock);
    @(negedge clock);
    check("rst_hold_q", q, 4'h0);
    #1;
    wren    = 1'b0;
    address = 5'h1F;
    reset_n = 1'b1;
    step(5'h1F, 4'h0, 1'b0);
    check("post_rst_mem0", q, exp_mem0);
    step(5'h1F, 4'h0, 1'b0);
    check("post_rst_1F", q, exp_1f);

    // Randomised traffic with occasional mid-cycle reset pulses
    for (int n = 0; n < 400; n++) begin
      step(5'($urandom_range(0, 31)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 63) == 0) begin
        #2 reset_n = 1'b0;
        @(negedge clock);
        #2 reset_n = 1'b1;
      end
    end
    step(5'd0, 4'h0, 1'b0);
    step(5'd0, 4'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
